// File: rtl/alu_ctrl_mc_if.sv
// alu_ctrl_mc_if: EX-stage bus between the ID/EX register, the ALU control/multiplier and the hazard unit.
//  Requests (master drives): valid_i, flush_i, ALU_op_i, funct_i, src1_i, src2_i.
//  Responses (slave drives): ALU_ctrl_o, ALU_ex_ctrl_o, stall_o, mul_done_o, mul_lo_o, mul_hi_o.
interface alu_ctrl_mc_if #(parameter int DATA_W = 32);
    logic              valid_i;
    logic              flush_i;
    logic [5:0]        ALU_op_i;
    logic [5:0]        funct_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic [3:0]        ALU_ctrl_o;
    logic [2:0]        ALU_ex_ctrl_o;
    logic              stall_o;
    logic              mul_done_o;
    logic [DATA_W-1:0] mul_lo_o;
    logic [DATA_W-1:0] mul_hi_o;
    modport master (
        output valid_i, flush_i, ALU_op_i, funct_i, src1_i, src2_i,
        input  ALU_ctrl_o, ALU_ex_ctrl_o, stall_o, mul_done_o, mul_lo_o, mul_hi_o
    );
    modport slave (
        input  valid_i, flush_i, ALU_op_i, funct_i, src1_i, src2_i,
        output ALU_ctrl_o, ALU_ex_ctrl_o, stall_o, mul_done_o, mul_lo_o, mul_hi_o
    );
endinterface

// File: rtl/alu_ctrl_mc.sv
// alu_ctrl_mc: EX-stage ALU/branch-compare decode plus an iterative shift-add multiplier that stalls the pipeline.
//  clk_i/rst_n : clock (rising edge) and asynchronous active-low reset.
//  bus (slave) : valid_i/flush_i/ALU_op_i/funct_i/src1_i/src2_i in; ALU_ctrl_o/ALU_ex_ctrl_o decode,
//                stall_o to the hazard unit, mul_done_o pulse with mul_lo_o/mul_hi_o product out.
//  Define MUL_SIGNED_EN for a two's-complement multiply; otherwise the multiply is unsigned.
module alu_ctrl_mc #(
    parameter int  DATA_W = 32,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input logic          clk_i,
    input logic          rst_n,
    alu_ctrl_mc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   mcand_q, lo_q, hi_q, mcand_d, mplier_d;
    logic [2*DATA_W-1:0] acc_q, acc_d, prod_d;
    logic [DATA_W:0]     sum_d;
    logic                done_q, is_mul, last;
    logic [3:0]          ctrl;
    logic [2:0]          ex_ctrl;
    always_comb begin
        ctrl    = 4'b0000;
        ex_ctrl = 3'b000;
        case (bus.ALU_op_i)
            6'b000000: ctrl = bus.funct_i == 6'b100000 ? 4'b0010 :
                              bus.funct_i == 6'b100010 ? 4'b0110 :
                              bus.funct_i == 6'b100101 ? 4'b0001 :
                              bus.funct_i == 6'b101010 ? 4'b0111 :
                              bus.funct_i == 6'b011000 ? 4'b0011 : 4'b0000;
            6'b001000, 6'b100011, 6'b101011: ctrl = 4'b0010;
            6'b000100, 6'b000101: begin ctrl = 4'b0111; ex_ctrl = 3'b100; end
            6'b000111: begin ctrl = 4'b0111; ex_ctrl = 3'b001; end
            6'b000001: begin ctrl = 4'b0111; ex_ctrl = 3'b011; end
            default: ;
        endcase
    end
    assign bus.ALU_ctrl_o    = ctrl;
    assign bus.ALU_ex_ctrl_o = ex_ctrl;
    assign is_mul = bus.valid_i && bus.ALU_op_i == 6'b000000 && bus.funct_i == 6'b011000;
    // Gated by rst_n so the hazard unit never sees a stall while the block is held in reset.
    assign bus.stall_o    = rst_n && !bus.flush_i && (state_q == BUSY || is_mul);
    assign bus.mul_done_o = done_q;
    assign bus.mul_lo_o   = lo_q;
    assign bus.mul_hi_o   = hi_q;
    assign last = cnt_q == CNT_W'(DATA_W - 1);
    // Multiplier sits in the low half of the accumulator and is consumed LSB-first as the product shifts in.
    assign sum_d = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_d = {sum_d, acc_q[DATA_W-1:1]};
`ifdef MUL_SIGNED_EN
    logic neg_q;
    assign mcand_d  = bus.src1_i[DATA_W-1] ? -bus.src1_i : bus.src1_i;
    assign mplier_d = bus.src2_i[DATA_W-1] ? -bus.src2_i : bus.src2_i;
    assign prod_d   = neg_q ? -acc_d : acc_d;
`else
    assign mcand_d  = bus.src1_i;
    assign mplier_d = bus.src2_i;
    assign prod_d   = acc_d;
`endif
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
`ifdef MUL_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else if (bus.flush_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        lo_q    <= prod_d[DATA_W-1:0];
                        hi_q    <= prod_d[2*DATA_W-1:DATA_W];
                    end
                end
                default: begin
                    state_q <= is_mul ? BUSY : IDLE;
                    if (is_mul) begin
                        mcand_q <= mcand_d;
                        acc_q   <= {{DATA_W{1'b0}}, mplier_d};
                        cnt_q   <= '0;
`ifdef MUL_SIGNED_EN
                        neg_q   <= bus.src1_i[DATA_W-1] ^ bus.src2_i[DATA_W-1];
`endif
                    end
                end
            endcase
        end
    end
endmodule
